bitwise_frame_reducer: RTL and testbench

Parametrised successor to the two-input gate primitives. It reduces a frame of 1..2^LEN_W operand words of WIDTH bits, applying a run-time selectable bitwise operation (OR, AND, XOR or NOR) across all operands. Operands arrive on a valid/ready input stream and the registered result leaves on a valid/ready output stream. It sits between a lab stimulus source and a result sink or display register.

---
 rtl/bitwise_frame_reducer.sv | 154 +++++++++++++++
 tb/tb_bitwise_frame_reducer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_frame_reducer.sv
// Purpose : reduce a frame of 1..2^LEN_W operand words with a run-time selectable bitwise OR/AND/XOR/NOR.
// Latency : out_valid rises the cycle after the final operand handshake; result is registered.
// Backpr. : in_ready is high only in ACCUM; out_data/out_valid hold in DONE until out_ready.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start, op, len      frame start request (IDLE only); op and len latched with it
//   in_valid/in_ready/in_data     operand stream
//   out_valid/out_ready/out_data  result stream
//   busy, beat_cnt      frame in progress, operands accepted so far
//   out_zero            result-is-zero flag, present only when ZERO_FLAG_EN is defined
// Optional feature macro: ZERO_FLAG_EN

module bitwise_frame_reducer #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
`ifdef ZERO_FLAG_EN
  output logic [LEN_W-1:0] beat_cnt,
  output logic             out_zero
`else
  output logic [LEN_W-1:0] beat_cnt
`endif
);

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ACCUM = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       op_q;
  logic [LEN_W-1:0] len_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] result;
  logic             beat;
  logic             last_beat;

  assign beat      = in_valid & in_ready;
  // Compare before increment so a full 2^LEN_W frame never wraps beat_cnt.
  assign last_beat = beat && (beat_cnt == len_q);

  // NOR accumulates as OR; the inversion is applied once on the final result.
  always_comb begin
    acc_nxt = acc;
    case (op_q)
      OP_OR,
      OP_NOR:  acc_nxt = acc | in_data;
      OP_AND:  acc_nxt = acc & in_data;
      OP_XOR:  acc_nxt = acc ^ in_data;
      default: acc_nxt = acc;
    endcase
  end

  assign result = (op_q == OP_NOR) ? ~acc_nxt : acc_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)     state_nxt = S_ACCUM;
      S_ACCUM: if (last_beat) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: configuration latch, accumulator, beat counter, result register
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_OR;
      len_q    <= '0;
      acc      <= '0;
      beat_cnt <= '0;
      out_data <= '0;
`ifdef ZERO_FLAG_EN
      out_zero <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q     <= op;
            len_q    <= len;
            acc      <= (op == OP_AND) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
            beat_cnt <= '0;
          end
        end
        S_ACCUM: begin
          if (beat) begin
            acc <= acc_nxt;
            if (last_beat) begin
              out_data <= result;
`ifdef ZERO_FLAG_EN
              out_zero <= (result == '0);
`endif
            end else begin
              beat_cnt <= beat_cnt + {{(LEN_W-1){1'b0}}, 1'b1};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitwise_frame_reducer.sv
// Purpose : self-checking bench for bitwise_frame_reducer (WIDTH=8, LEN_W=4).
// Latency : inputs driven 1 time unit after posedge, outputs sampled at that point.
// Backpr. : exercises out_ready hold-off in DONE with start/in_valid activity.

module tb_bitwise_frame_reducer;

  localparam int WIDTH = 8;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             busy;
  logic [LEN_W-1:0] beat_cnt;
`ifdef ZERO_FLAG_EN
  logic             out_zero;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] frame_dat [16];

  always #5 clk = ~clk;

  bitwise_frame_reducer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
`ifdef ZERO_FLAG_EN
    .beat_cnt  (beat_cnt),
    .out_zero  (out_zero)
`else
    .beat_cnt  (beat_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: per bit, count how many operands have it set, then apply
  // the operation's definition (any / all / odd / none).
  function automatic logic [WIDTH-1:0] model(input logic [1:0] f_op, input int n);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int b = 0; b < WIDTH; b++) begin
      int ones;
      ones = 0;
      for (int i = 0; i < n; i++) ones += int'(frame_dat[i][b]);
      case (f_op)
        2'b00:   r[b] = (ones > 0);
        2'b01:   r[b] = (ones == n);
        2'b10:   r[b] = (ones % 2) == 1;
        default: r[b] = (ones == 0);
      endcase
    end
    return r;
  endfunction

  // gap_mode: 0 = back-to-back, 1 = two idle cycles between beats, 2 = random 0..2
  task automatic run_frame(input logic [1:0] f_op, input int f_len, input int gap_mode,
                           input int bp_cycles, input logic [WIDTH-1:0] exp);
    int gaps;
    // Start cycle; a stray in_valid here must be ignored (in_ready=0 in IDLE).
    start    = 1'b1;
    op       = f_op;
    len      = LEN_W'(f_len);
    in_valid = 1'b1;
    in_data  = WIDTH'($urandom);
    check("idle_in_ready", in_ready, 0);
    tick;
    in_valid = 1'b0;
    start    = 1'b0;
    check("accum_busy", busy, 1);
    for (int i = 0; i <= f_len; i++) begin
      gaps = (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gaps; g++) begin
        in_valid  = 1'b0;
        in_data   = WIDTH'($urandom);
        // start with a different op and out_ready while busy must not disturb the frame
        start     = 1'($urandom);
        op        = 2'($urandom);
        out_ready = 1'($urandom);
        tick;
        check("gap_in_ready", in_ready, 1);
        check("gap_beat_cnt", beat_cnt, i);
      end
      in_valid = 1'b1;
      in_data  = frame_dat[i];
      tick;
    end
    in_valid  = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    check("done_out_valid", out_valid, 1);
    check("done_out_data", out_data, exp);
    check("done_beat_cnt", beat_cnt, f_len);
    check("done_in_ready", in_ready, 0);
`ifdef ZERO_FLAG_EN
    check("done_out_zero", out_zero, (exp == '0));
`endif
    for (int c = 0; c < bp_cycles; c++) begin
      start    = 1'($urandom);
      op       = 2'($urandom);
      len      = LEN_W'($urandom);
      in_valid = 1'b1;
      in_data  = WIDTH'($urandom);
      tick;
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, exp);
      check("bp_in_ready", in_ready, 0);
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("ret_out_valid", out_valid, 0);
    check("ret_busy", busy, 0);
    check("ret_out_data_hold", out_data, exp);
  endtask

  initial begin
    logic [1:0] r_op;
    int         r_len;

    rst       = 1'b1;
    start     = 1'b0;
    op        = 2'b00;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick;
    tick;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_beat_cnt", beat_cnt, 0);
`ifdef ZERO_FLAG_EN
    check("rst_out_zero", out_zero, 0);
`endif
    rst = 1'b0;
    tick;

    // 1: OR of single-bit operands
    frame_dat[0] = 8'h01; frame_dat[1] = 8'h02; frame_dat[2] = 8'h04; frame_dat[3] = 8'h80;
    run_frame(2'b00, 3, 0, 0, 8'h87);
    // 2: AND with two-cycle gaps
    frame_dat[0] = 8'hFF; frame_dat[1] = 8'hF0; frame_dat[2] = 8'h3C;
    run_frame(2'b01, 2, 1, 0, 8'h30);
    // 3: XOR to zero
    frame_dat[0] = 8'hAA; frame_dat[1] = 8'h55; frame_dat[2] = 8'hFF;
    run_frame(2'b10, 2, 0, 0, 8'h00);
    // 4: NOR single operand, then a full-length NOR frame of zeros
    frame_dat[0] = 8'h0F;
    run_frame(2'b11, 0, 0, 0, 8'hF0);
    for (int i = 0; i < 16; i++) frame_dat[i] = 8'h00;
    run_frame(2'b11, 15, 0, 0, 8'hFF);
    // 5: backpressure in DONE for five cycles
    frame_dat[0] = 8'h11; frame_dat[1] = 8'h22;
    run_frame(2'b00, 1, 0, 5, 8'h33);

    // 6: reset mid-frame discards the partial accumulation
    start = 1'b1; op = 2'b00; len = 4'd3;
    tick;
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h10;
    tick;
    in_data = 8'h20;
    tick;
    in_valid = 1'b0;
    check("mid_beat_cnt", beat_cnt, 2);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_beat_cnt", beat_cnt, 0);
    check("mid_rst_in_ready", in_ready, 0);
    frame_dat[0] = 8'h01;
    run_frame(2'b00, 0, 0, 0, 8'h01);

    // Randomized frames against the reference model
    for (int f = 0; f < 40; f++) begin
      r_op  = 2'($urandom);
      r_len = int'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) begin
        // bias some frames toward sparse/dense words so AND/OR/NOR outcomes vary
        case (f % 3)
          0:       frame_dat[i] = WIDTH'($urandom);
          1:       frame_dat[i] = WIDTH'($urandom) & WIDTH'($urandom) & WIDTH'($urandom);
          default: frame_dat[i] = WIDTH'($urandom) | WIDTH'($urandom) | WIDTH'($urandom);
        endcase
      end
      run_frame(r_op, r_len, 2, int'($urandom_range(0, 3)), model(r_op, r_len + 1));
      // idle cycles between frames must not change anything
      if ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b1;
        in_data  = WIDTH'($urandom);
        tick;
        in_valid = 1'b0;
        check("idle_busy", busy, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
